key_arbiter: RTL and testbench

- Collects one-cycle key pulses from N_KEYS edge-detected switch channels (coin/select/cancel buttons).
- Latches each pulse as a pending request.
- Serialises pending requests onto one valid/ready channel that feeds the vending controller's credit/selection logic.
- Round-robin grant, so no button can starve another; counts presses lost because the same button was still pending.

---
 rtl/key_arbiter.sv | 121 ++++++++++++
 tb/tb_key_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/key_arbiter.sv
// Pending-request latch and round-robin serialiser for edge-detected key pulses.
// Define KEY_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module key_arbiter #(
  parameter int N_KEYS = 4,
  parameter int IDX_W  = 2,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_pulse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_key,
  output logic [N_KEYS-1:0] out_onehot,
  output logic [N_KEYS-1:0] pending,
  output logic [DROP_W-1:0] drop_count,
  input  logic              clr_drop
);

  localparam int CNT_W = $clog2(N_KEYS + 1);
  localparam int SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_key;
  logic [N_KEYS-1:0]   r_pending;
  logic [DROP_W-1:0]   r_drop;
  logic [N_KEYS-1:0]   w_accept_vec, w_drop_vec;
  logic [IDX_W-1:0]    w_base, w_hi, w_lo, w_win;
  logic                w_hi_found;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_KEYS-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < N_KEYS; i++) s = s + CNT_W'(v[i]);
    return s;
  endfunction

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({DROP_W{1'b1}})) return {DROP_W{1'b1}};
    return s[DROP_W-1:0];
  endfunction

`ifdef KEY_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [IDX_W-1:0] r_rr_ptr;
  assign w_base = r_rr_ptr;

  always_ff @(posedge clk) begin
    if (reset)
      r_rr_ptr <= '0;
    else if (r_state == OFFER && out_ready)
      r_rr_ptr <= (r_key == IDX_W'(N_KEYS - 1)) ? '0 : r_key + 1'b1;
  end
`endif

  // Winner: lowest set bit at or above the base, else wrap to lowest set bit overall.
  always_comb begin
    w_hi       = '0;
    w_lo       = '0;
    w_hi_found = 1'b0;
    for (int j = N_KEYS - 1; j >= 0; j--) begin
      if (r_pending[j]) begin
        w_lo = IDX_W'(j);
        if (IDX_W'(j) >= w_base) begin
          w_hi       = IDX_W'(j);
          w_hi_found = 1'b1;
        end
      end
    end
    w_win = w_hi_found ? w_hi : w_lo;
  end

  always_comb begin
    out_onehot = '0;
    for (int i = 0; i < N_KEYS; i++)
      out_onehot[i] = (r_state == OFFER) && (r_key == IDX_W'(i));
  end

  assign out_valid    = (r_state == OFFER);
  assign out_key      = (r_state == OFFER) ? r_key : '0;
  assign pending      = r_pending;
  assign drop_count   = r_drop;
  assign w_accept_vec = out_onehot & {N_KEYS{out_ready}};
  assign w_drop_vec   = key_pulse & r_pending & ~w_accept_vec;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_pending != '0) w_state_nxt = OFFER;
      OFFER:   if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Winner is captured only on the IDLE->OFFER transition so the offer stays stable.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && r_pending != '0) r_key <= w_win;
  end

  always_ff @(posedge clk) begin
    if (reset) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_accept_vec) | key_pulse;
  end

  always_ff @(posedge clk) begin
    if (reset || clr_drop) r_drop <= '0;
    else                   r_drop <= sat_add(r_drop, popcount(w_drop_vec));
  end

endmodule

// File: tb/tb_key_arbiter.sv
// Directed table-driven bench for key_arbiter (N_KEYS=4, DROP_W=2) plus a grant-order sequence.
module tb_key_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_pulse = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_key;
  logic [3:0] out_onehot;
  logic [3:0] pending;
  logic [1:0] drop_count;
  logic       clr_drop = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  key_arbiter #(.N_KEYS(4), .IDX_W(2), .DROP_W(2)) dut (
    .clk(clk), .reset(reset), .key_pulse(key_pulse),
    .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
    .out_onehot(out_onehot), .pending(pending), .drop_count(drop_count),
    .clr_drop(clr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] kp;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [1:0] ek;
    logic [3:0] eoh;
    logic [3:0] epend;
    logic [1:0] edrop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] kp, input logic rdy, input logic clr,
                     input logic ev, input logic [1:0] ek, input logic [3:0] eoh,
                     input logic [3:0] epend, input logic [1:0] edrop);
    vec_t v;
    v.rst = rst; v.kp = kp; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ek = ek; v.eoh = eoh; v.epend = epend; v.edrop = edrop;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [1:0] got[5];
    logic [1:0] exp_order[5];
    int n;
    bit sent3;

    //  rst  kp      rdy  clr   v   key  onehot   pending  drop
    add(1, 4'b0000, 0, 0,   0, 0, 4'b0000, 4'b0000, 0); // 0 reset state
    add(0, 4'b0100, 1, 0,   0, 0, 4'b0000, 4'b0100, 0); // single press key 2
    add(0, 4'b0000, 1, 0,   1, 2, 4'b0100, 4'b0100, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 0,   0, 0, 4'b0000, 4'b0000, 0); // 4 reset, rr back to 0
    add(0, 4'b1011, 1, 0,   0, 0, 4'b0000, 4'b1011, 0);
    add(0, 4'b0000, 1, 0,   1, 0, 4'b0001, 4'b1011, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b1010, 0);
    add(0, 4'b0000, 1, 0,   1, 1, 4'b0010, 4'b1010, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b1000, 0);
    add(0, 4'b0000, 1, 0,   1, 3, 4'b1000, 4'b1000, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 1, 0,   0, 0, 4'b0000, 4'b0011, 0); // 12 pointer wrapped to 0
    add(0, 4'b0000, 1, 0,   1, 0, 4'b0001, 4'b0011, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0010, 0);
    add(0, 4'b0000, 1, 0,   1, 1, 4'b0010, 4'b0010, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, 0, 0,   0, 0, 4'b0000, 4'b0010, 0); // 17 backpressure
    for (int i = 0; i < 5; i++)
      add(0, 4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0010, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, 0, 0,   0, 0, 4'b0000, 4'b0001, 0); // 25 drops, saturation
    add(0, 4'b0001, 0, 0,   1, 0, 4'b0001, 4'b0001, 1);
    add(0, 4'b0001, 0, 0,   1, 0, 4'b0001, 4'b0001, 2);
    add(0, 4'b0001, 0, 0,   1, 0, 4'b0001, 4'b0001, 3);
    add(0, 4'b0001, 0, 0,   1, 0, 4'b0001, 4'b0001, 3);
    add(0, 4'b0001, 0, 1,   1, 0, 4'b0001, 4'b0001, 0); // clear beats drop
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1000, 0, 0,   0, 0, 4'b0000, 4'b1000, 0); // 32 pulse coincident with accept
    add(0, 4'b0000, 0, 0,   1, 3, 4'b1000, 4'b1000, 0);
    add(0, 4'b1000, 1, 0,   0, 0, 4'b0000, 4'b1000, 0);
    add(0, 4'b0000, 0, 0,   1, 3, 4'b1000, 4'b1000, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1110, 0, 0,   0, 0, 4'b0000, 4'b1110, 0); // 37 reset mid-offer
    add(0, 4'b0000, 0, 0,   1, 1, 4'b0010, 4'b1110, 0);
    add(0, 4'b0110, 0, 0,   1, 1, 4'b0010, 4'b1110, 2); // two drops in one cycle
    add(1, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 0);

    foreach (tbl[i]) begin
      reset     = tbl[i].rst;
      key_pulse = tbl[i].kp;
      out_ready = tbl[i].rdy;
      clr_drop  = tbl[i].clr;
      step();
      chk("out_valid",  i, 8'(out_valid),  8'(tbl[i].ev));
      chk("out_key",    i, 8'(out_key),    8'(tbl[i].ek));
      chk("out_onehot", i, 8'(out_onehot), 8'(tbl[i].eoh));
      chk("pending",    i, 8'(pending),    8'(tbl[i].epend));
      chk("drop_count", i, 8'(drop_count), 8'(tbl[i].edrop));
    end

    // Grant order with re-press of key 1 on its own accept edge, then a fresh 1010 burst.
`ifdef KEY_ARB_FIXED_PRIO_EN
    exp_order = '{2'd1, 2'd1, 2'd3, 2'd1, 2'd3};
`else
    exp_order = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
`endif
    reset = 1'b1; key_pulse = '0; out_ready = 1'b0; clr_drop = 1'b0;
    step();
    reset = 1'b0; key_pulse = 4'b1010;
    step();
    out_ready = 1'b1;
    n = 0;
    sent3 = 1'b0;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      key_pulse = '0;
      if (out_valid) begin
        got[n] = out_key;
        n++;
        if (n == 1) key_pulse = 4'b0010;
      end else if (n == 3 && pending == 4'b0000 && !sent3) begin
        key_pulse = 4'b1010;
        sent3 = 1'b1;
      end
      step();
    end
    key_pulse = '0;
    chk("grant_count", 0, 8'(n), 8'd5);
    for (int k = 0; k < 5; k++)
      if (k < n) chk("grant_order", k, 8'(got[k]), 8'(exp_order[k]));
    chk("order_drops", 0, 8'(drop_count), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
